// File: rtl/bsg_util_link_gpio_master_pkg.sv
// Shared types and helpers for the util-link GPIO master: FSM encoding,
// header length value and link-width arithmetic.
package bsg_util_link_gpio_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } gpio_master_state_e;

    // Every set-bit packet is a header plus exactly one payload flit.
    localparam int unsigned HDR_LEN_VAL = 1;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Flat link layout: {v, data[flit-1:0], ready_and_rev}.
    function automatic int link_sif_width(input int flit_width);
        return flit_width + 2;
    endfunction

endpackage

// File: rtl/bsg_util_link_gpio_master_penc.sv
// Lowest-index-first priority encoder used to pick the next GPIO bit to send.
module bsg_util_link_gpio_master_penc #(
    parameter int width_p    = 8,
    parameter int lg_width_p = 3
) (
    input  logic [width_p-1:0]    req_i,
    output logic [lg_width_p-1:0] addr_o,
    output logic                  v_o
);

    always_comb begin
        addr_o = '0;
        v_o    = |req_i;
        // Scan downwards so the lowest set index is the last to win.
        for (int k = width_p - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                addr_o = lg_width_p'(k);
            end
        end
    end

endmodule

// File: rtl/bsg_util_link_gpio_master.sv
// Mirrors gpio_i onto a remote GPIO register, one two-flit set-bit packet per
// bit that differs from the local shadow copy or has been marked for resync.
module bsg_util_link_gpio_master
    import bsg_util_link_gpio_master_pkg::*;
#(
    parameter int flit_width_p = 16,
    parameter int num_gpio_p   = 8,
    parameter int cord_width_p = 8,
    parameter int len_width_p  = 4,
    localparam int lg_num_gpio_lp                  = safe_clog2(num_gpio_p),
    localparam int bsg_ready_and_link_sif_width_lp = link_sif_width(flit_width_p)
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,
    input  logic [num_gpio_p-1:0]                      gpio_i,
    input  logic                                       resync_i,
    input  logic [cord_width_p-1:0]                    dest_cord_i,
    output logic                                       busy_o,
    input  logic [bsg_ready_and_link_sif_width_lp-1:0] link_i,
    output logic [bsg_ready_and_link_sif_width_lp-1:0] link_o
);

    gpio_master_state_e        state_q;
    logic [num_gpio_p-1:0]     shadow_q;
    logic [num_gpio_p-1:0]     dirty_q;
    logic [lg_num_gpio_lp-1:0] sel_q;
    logic                      val_q;

    logic [num_gpio_p-1:0]     pend;
    logic [lg_num_gpio_lp-1:0] pend_sel;
    logic                      pend_v;
    logic                      ready_and;
    logic                      link_v;
    logic [flit_width_p-1:0]   link_data;
    logic                      unused_link;

    assign ready_and   = link_i[0];
    assign unused_link = ^link_i[bsg_ready_and_link_sif_width_lp-1:1];

    assign pend = (gpio_i ^ shadow_q) | dirty_q;

    bsg_util_link_gpio_master_penc #(
        .width_p   (num_gpio_p),
        .lg_width_p(lg_num_gpio_lp)
    ) u_penc (
        .req_i (pend),
        .addr_o(pend_sel),
        .v_o   (pend_v)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            shadow_q <= '1;
            dirty_q  <= '0;
            sel_q    <= '0;
            val_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pend_v) begin
                        sel_q   <= pend_sel;
                        val_q   <= gpio_i[pend_sel];
                        state_q <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (ready_and) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (ready_and) begin
                        shadow_q[sel_q] <= val_q;
                        dirty_q[sel_q]  <= 1'b0;
                        state_q         <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // Placed last so a resync on the payload-accept cycle overrides the clear.
            if (resync_i) begin
                dirty_q <= '1;
            end
        end
    end

    always_comb begin
        link_data = '0;
        case (state_q)
            ST_HDR: begin
                link_data[cord_width_p +: len_width_p] = len_width_p'(HDR_LEN_VAL);
                link_data[0 +: cord_width_p]           = dest_cord_i;
            end
            ST_DATA: begin
                link_data[flit_width_p-1]     = val_q;
                link_data[lg_num_gpio_lp-1:0] = sel_q;
            end
            default: link_data = '0;
        endcase
    end

    assign link_v = (state_q != ST_IDLE);
    assign link_o = {link_v, link_data, 1'b1};
    assign busy_o = link_v | (|pend);

endmodule

// File: tb/tb_bsg_util_link_gpio_master.sv
// Directed and randomized checks of the GPIO master against a remote-register
// model fed by the flits the link actually accepts.
module tb_bsg_util_link_gpio_master;

    localparam int FW = 16;
    localparam int NG = 8;
    localparam int CW = 8;
    localparam int LW = 4;
    localparam int SW = FW + 2;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [NG-1:0] gpio_i;
    logic          resync_i;
    logic [CW-1:0] dest;
    logic          busy_o;
    logic          ready;
    logic [SW-1:0] link_i;
    logic [SW-1:0] link_o;

    logic          lo_v;
    logic [FW-1:0] lo_data;
    logic          lo_rdy;

    assign link_i  = {1'b0, {FW{1'b0}}, ready};
    assign lo_v    = link_o[SW-1];
    assign lo_data = link_o[FW:1];
    assign lo_rdy  = link_o[0];

    always #5 clk = ~clk;

    bsg_util_link_gpio_master #(
        .flit_width_p(FW),
        .num_gpio_p  (NG),
        .cord_width_p(CW),
        .len_width_p (LW)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .gpio_i     (gpio_i),
        .resync_i   (resync_i),
        .dest_cord_i(dest),
        .busy_o     (busy_o),
        .link_i     (link_i),
        .link_o     (link_o)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Remote endpoint model: deserialises accepted flits into a register.
    logic [NG-1:0] remote;
    int            pq[$];
    int            eq[$];
    bit            expect_hdr;
    int            bad_fmt = 0;
    int            stall_err = 0;
    bit            prev_stall;
    logic [FW-1:0] prev_data;

    always @(negedge clk) begin
        if (reset_i) begin
            remote     = '1;
            expect_hdr = 1'b1;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!lo_v || lo_data != prev_data)) stall_err++;
            prev_stall = lo_v && !ready;
            prev_data  = lo_data;
            if (lo_v && ready) begin
                if (expect_hdr) begin
                    if (lo_data != {4'h0, 4'h1, dest}) bad_fmt++;
                    expect_hdr = 1'b0;
                end else begin
                    if (lo_data[14:3] != 12'h000) bad_fmt++;
                    remote[lo_data[2:0]] = lo_data[15];
                    pq.push_back(int'({lo_data[15], lo_data[2:0]}));
                    $display("pkt  sel=%0d val=%0d  t=%0t", lo_data[2:0], lo_data[15], $time);
                    expect_hdr = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!busy_o) break;
        end
        chk("idle_in_budget", 32'(k < budget), 32'd1);
    endtask

    task automatic chk_pkts(input string tag);
        chk({tag, "_count"}, 32'(pq.size()), 32'(eq.size()));
        for (int i = 0; i < eq.size() && i < pq.size(); i++) begin
            chk({tag, "_pkt"}, 32'(pq[i]), 32'(eq[i]));
        end
        pq.delete();
        eq.delete();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        repeat (3) tick();
        reset_i = 1'b0;
        pq.delete();
    endtask

    initial begin
        int cnt;
        ready    = 1'b1;
        reset_i  = 1'b1;
        gpio_i   = '1;
        resync_i = 1'b0;
        dest     = 8'h5A;

        // Reset state
        tick();
        @(negedge clk);
        chk("rst_v", 32'(lo_v), 32'd0);
        chk("rst_data", 32'(lo_data), 32'd0);
        chk("rst_rdy", 32'(lo_rdy), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        tick();
        reset_i = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("idle_no_pkt", 32'(pq.size()), 32'd0);
        chk("idle_busy", 32'(busy_o), 32'd0);

        // Single mismatch, cycle-exact timing
        tick();
        gpio_i = 8'hFB;
        @(negedge clk);
        chk("t0_busy", 32'(busy_o), 32'd1);
        chk("t0_v", 32'(lo_v), 32'd0);
        tick();
        @(negedge clk);
        chk("t1_v", 32'(lo_v), 32'd1);
        chk("t1_hdr", 32'(lo_data), 32'h015A);
        tick();
        @(negedge clk);
        chk("t2_v", 32'(lo_v), 32'd1);
        chk("t2_payload", 32'(lo_data), 32'h0002);
        tick();
        @(negedge clk);
        chk("t3_v", 32'(lo_v), 32'd0);
        chk("t3_busy", 32'(busy_o), 32'd0);
        eq.push_back(2);
        chk_pkts("fb");
        chk("fb_remote", 32'(remote), 32'hFB);

        // All bits cleared from reset: 8 back-to-back packets
        tick();
        do_reset();
        gpio_i = 8'h00;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy_o) break;
            cnt++;
        end
        chk("all0_busy_cycles", 32'(cnt), 32'd24);
        for (int i = 0; i < NG; i++) eq.push_back(i);
        chk_pkts("all0");
        chk("all0_remote", 32'(remote), 32'h00);

        // Backpressure in HDR and in DATA
        tick();
        ready  = 1'b0;
        gpio_i = 8'h10;
        repeat (5) tick();
        @(negedge clk);
        chk("bp_hdr_v", 32'(lo_v), 32'd1);
        chk("bp_hdr", 32'(lo_data), 32'h015A);
        tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        chk("bp_data_v", 32'(lo_v), 32'd1);
        chk("bp_data", 32'(lo_data), 32'h8004);
        tick();
        ready = 1'b1;
        wait_idle(100);
        eq.push_back(12);
        chk_pkts("bp");
        chk("bp_remote", 32'(remote), 32'h10);
        chk("bp_stable", 32'(stall_err), 32'd0);

        // Resync with nothing mismatched resends every bit
        tick();
        resync_i = 1'b1;
        tick();
        resync_i = 1'b0;
        wait_idle(200);
        for (int i = 0; i < NG; i++) eq.push_back((((8'h10 >> i) & 1) << 3) | i);
        chk_pkts("resync");

        // Resync on the payload-accept cycle: that bit goes out again
        tick();
        gpio_i = 8'h11;
        tick();
        tick();
        resync_i = 1'b1;
        tick();
        resync_i = 1'b0;
        wait_idle(200);
        eq.push_back(8);
        for (int i = 0; i < NG; i++) eq.push_back((((8'h11 >> i) & 1) << 3) | i);
        chk_pkts("resync_acc");
        chk("resync_acc_remote", 32'(remote), 32'h11);

        // Bit 3 toggles back while its packet is in flight
        tick();
        gpio_i = 8'hFF;
        wait_idle(200);
        pq.delete();
        tick();
        gpio_i = 8'hF7;
        tick();
        gpio_i = 8'hFF;
        wait_idle(200);
        eq.push_back(3);
        eq.push_back(11);
        chk_pkts("toggle3");
        chk("toggle3_remote", 32'(remote), 32'hFF);

        // Randomized gpio/resync/backpressure: remote must converge each round
        for (int it = 0; it < 20; it++) begin
            for (int c = 0; c < 40; c++) begin
                tick();
                ready    = ($urandom_range(0, 3) != 0);
                resync_i = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 7) == 0) gpio_i = 8'($urandom);
            end
            tick();
            ready    = 1'b1;
            resync_i = 1'b0;
            wait_idle(300);
            chk("rand_converge", 32'(remote), 32'(gpio_i));
            pq.delete();
        end
        chk("hdr_fmt", 32'(bad_fmt), 32'd0);
        chk("flit_stable", 32'(stall_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bsg_util_link_gpio_master.md
# bsg_util_link_gpio_master

Transmit-side counterpart of the utility-link GPIO endpoint. Mirrors a local `gpio_i` vector onto a remote GPIO register by sending two-flit set-bit packets (header, then payload) over a `bsg_ready_and_link_sif` link. It keeps a shadow copy of the remote register state and sends one packet per bit that differs from the shadow or is marked for resync. It sits on the board-controller side of the util link, facing the GPIO endpoint across the NoC.

## Interface
- `flit_width_p`, no default ("inv"), link flit width; must be ≥ `cord_width_p + len_width_p` and ≥ `lg_num_gpio_lp + 1`.
- `num_gpio_p`, no default ("inv"), number of mirrored GPIO bits.
- `cord_width_p`, no default ("inv"), destination coordinate width.
- `len_width_p`, no default ("inv"), packet length field width.
- `lg_num_gpio_lp`, localparam = `BSG_SAFE_CLOG2(num_gpio_p)`.
- `bsg_ready_and_link_sif_width_lp`, localparam = `bsg_ready_and_link_sif_width(flit_width_p)`.
- Clock and reset: one clock `clk_i`; `reset_i` is synchronous and active-high.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  synchronous active-high reset.
- `gpio_i`  in  `num_gpio_p`  desired remote GPIO state; may change any cycle.
- `resync_i`  in  1  one-cycle pulse; marks all bits dirty.
- `dest_cord_i`  in  `cord_width_p`  destination coordinate; quasi-static.
- `busy_o`  out  1  high when a packet is in flight or any bit is dirty or mismatched.
- `link_i`  in  `bsg_ready_and_link_sif_width_lp`  only `ready_and_rev` is used; `v` and `data` are ignored.
- `link_o`  out  `bsg_ready_and_link_sif_width_lp`  carries `v` and `data`; `ready_and_rev` is tied to 1 (sinks and discards any return traffic).

## Operation
- Registers:
  - `shadow_r[num_gpio_p]`, reset to all 1s (matches the endpoint's reset value).
  - `dirty_r[num_gpio_p]`, reset to 0.
  - `sel_r`, `val_r`.
  - 2-bit FSM state.
- `pend = (gpio_i ^ shadow_r) | dirty_r`.
- FSM states:
  - IDLE: `link_o.v = 0`. If `pend != 0`, latch `sel_r` = lowest set index of `pend` and `val_r = gpio_i[sel_r]`, then go to HDR.
  - HDR: `v = 1`. Data = {zeros, len = 1 in bits `[cord_width_p +: len_width_p]`, `dest_cord_i` in bits `[0 +: cord_width_p]`}. When `ready_and_rev` is high, go to DATA.
  - DATA: `v = 1`. Data = {`val_r` in bit `[flit_width_p-1]`, zeros, `sel_r` in bits `[lg_num_gpio_lp-1:0]`}. When `ready_and_rev` is high:
    - `shadow_r[sel_r] <= val_r`;
    - `dirty_r[sel_r] <= 0`, unless `resync_i` is asserted in the same cycle, which wins and sets all dirty bits;
    - go to IDLE.
- `resync_i` in any state: `dirty_r <= '1`. Does not abort the packet in flight.
- `gpio_i` changing while a packet is in flight: the latched `val_r` is still sent. The new mismatch is picked up on return to IDLE. The remote always converges to the final `gpio_i`.
- Once the header is issued, `v` stays high until the payload is accepted (no retraction).
- `dest_cord_i` is sampled live in HDR only.
- `busy_o = (state != IDLE) | (pend != 0)`.

## Timing
- Reset values: `link_o.v = 0`, `link_o.data = 0`, `link_o.ready_and_rev = 1`, `busy_o = 0` (given `gpio_i` all 1s).
- Mismatch visible in IDLE at cycle t → header valid at t+1 → payload valid at t+2 at the earliest (with ready held high) → IDLE at t+3 → next header at t+4. Throughput is one bit per 3 cycles.
- Backpressure: each flit holds its value while `ready_and_rev` is low.
- Reset mid-packet: return to IDLE and restore shadow/dirty reset values the next cycle. The remote endpoint must be reset in the same cycle, since a half packet would otherwise misalign its deserializer.
- Multiple mismatched bits are served lowest index first.

## Structure
- No new package. Link struct comes from `bsg_noc_links.vh` (`declare_bsg_ready_and_link_sif_s`).
- Sub-module: `bsg_priority_encode` (lo_to_hi) for `sel` selection.
- Header field layout (cord low, len above) shared with other util-link masters; defined by position constants in the module.

## Test plan
- Reset with `gpio_i = '1`, ready high → no packet, `busy_o = 0`.
- `num_gpio_p = 8`, `flit_width_p = 16`; drive `gpio_i = 8'hFB` → header (len 1, cord) then payload `16'h0002`; `busy_o` falls 1 cycle after acceptance.
- `gpio_i = 8'h00` → 8 packets, sel 0..7 in order, each with bit 15 = 0; a back-to-back paced endpoint model ends with `gpio_o = 8'h00`.
- Hold ready low 5 cycles during HDR and during DATA → flit stable, no duplicate, no drop.
- Pulse `resync_i` with no mismatch → 8 packets carrying the current values. Pulse `resync_i` on the same cycle as payload acceptance → that bit is re-sent.
- Toggle `gpio_i[3]` 1→0→1 while its packet is in flight → two packets for bit 3, final remote value 1.
